// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the counter run arbiter.
package cnt_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int CNT_SIZE_DEFAULT = 4;

   localparam int REQ_0 = 0;
   localparam int REQ_1 = 1;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin selector: ptr names the requester favoured on a tie.
module rr_pick_2
   import cnt_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] pick
);

   always_comb begin
      // NOTE: default assignment first so every path drives pick and no latch is inferred.
      pick = 2'b00;
      if (ptr == 1'b0) begin
         if (req[REQ_0])      pick = 2'b01;
         else if (req[REQ_1]) pick = 2'b10;
      end else begin
         if (req[REQ_1])      pick = 2'b10;
         else if (req[REQ_0]) pick = 2'b01;
      end
   end

endmodule

// File: rtl/cnt_run_arbiter.sv
// Shares one external up-counter between two requesters, one run of len counts per grant.
// Define CNT_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module cnt_run_arbiter
   import cnt_arb_pkg::*;
#(
   parameter int size = CNT_SIZE_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req,
   input  logic [size-1:0] len_0,
   input  logic [size-1:0] len_1,
   input  logic            hold,
   input  logic [size-1:0] count,
   output logic [1:0]      gnt,
   output logic [1:0]      done,
   output logic            busy,
   output logic            cnt_enable,
   output logic            cnt_clear
);

   state_e          state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic [1:0]      done_q, done_d;
   logic [size-1:0] len_q, len_d;
   logic [1:0]      pick;
   logic            abort;
   logic            at_len;

   // Granted requester withdrew while its run was still in progress.
   assign abort  = ((state_q == ST_CLEAR) || (state_q == ST_RUN)) && ((req & gnt_q) == 2'b00);
   assign at_len = (count == len_q);

`ifdef CNT_ARB_FIXED_PRI_EN
   assign pick = req[REQ_0] ? 2'b01 : (req[REQ_1] ? 2'b10 : 2'b00);
`else
   logic rr_q, rr_d;

   rr_pick_2 u_rr_pick (
      .req  (req),
      .ptr  (rr_q),
      .pick (pick)
   );

   always_comb begin
      rr_d = rr_q;
      if ((state_q == ST_DONE) || abort) rr_d = gnt_q[REQ_0];
   end

   always_ff @(posedge clk) begin
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = 2'b00;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: begin
            if (pick != 2'b00) begin
               gnt_d   = pick;
               len_d   = pick[REQ_1] ? len_1 : len_0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (abort) begin
               gnt_d   = 2'b00;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               gnt_d   = 2'b00;
               state_d = ST_IDLE;
            end else if (at_len) begin
               done_d  = gnt_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         len_q   <= len_d;
      end
   end

   assign gnt        = gnt_q;
   assign done       = done_q;
   assign busy       = (state_q != ST_IDLE);
   assign cnt_clear  = (state_q == ST_CLEAR);
   assign cnt_enable = (state_q == ST_RUN) && !hold && !at_len && !abort;

endmodule

// File: tb/tb_cnt_run_arbiter.sv
// Directed bench for cnt_run_arbiter with a behavioural counter attached to cnt_enable/cnt_clear.
module tb_cnt_run_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [3:0] len_0, len_1;
   logic       hold;
   logic [3:0] count;
   logic [1:0] gnt, done;
   logic       busy, cnt_enable, cnt_clear;

   int checks = 0;
   int errors = 0;

   logic [1:0] gnt_tr  [64];
   logic [1:0] done_tr [64];
   logic       en_tr   [64];
   logic       clr_tr  [64];
   logic       busy_tr [64];
   logic [3:0] cnt_tr  [64];

   cnt_run_arbiter #(.size(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .len_0      (len_0),
      .len_1      (len_1),
      .hold       (hold),
      .count      (count),
      .gnt        (gnt),
      .done       (done),
      .busy       (busy),
      .cnt_enable (cnt_enable),
      .cnt_clear  (cnt_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter datapath: clear is ORed with rst.
   always_ff @(posedge clk) begin
      if (rst || cnt_clear) count <= 4'd0;
      else if (cnt_enable)  count <= count + 4'd1;
   end

   // Cycle k is the interval after posedge k; inputs change and outputs are sampled at its negedge.
   task automatic record(input int n, input int hs, input int hn,
                         input int k1, input logic [1:0] r1,
                         input int k2, input logic [1:0] r2);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         hold = (k >= hs) && (k < hs + hn);
         if (k == k1) req = r1;
         if (k == k2) req = r2;
         #1;
         gnt_tr[k]  = gnt;
         done_tr[k] = done;
         en_tr[k]   = cnt_enable;
         clr_tr[k]  = cnt_clear;
         busy_tr[k] = busy;
         cnt_tr[k]  = count;
      end
      hold = 1'b0;
   endtask

   function automatic int sum_en(input int a, input int b);
      int s = 0;
      for (int k = a; k <= b; k++) s += int'(en_tr[k]);
      return s;
   endfunction

   function automatic int sum_clr(input int a, input int b);
      int s = 0;
      for (int k = a; k <= b; k++) s += int'(clr_tr[k]);
      return s;
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1; req = 2'b00; hold = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req = 2'b00; hold = 1'b0; len_0 = 4'd0; len_1 = 4'd0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (gnt !== 2'b00)     begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
      checks++; if (done !== 2'b00)    begin errors++; $display("FAIL reset_done got %b want 00", done); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", cnt_enable); end
      checks++; if (cnt_clear !== 1'b0)  begin errors++; $display("FAIL reset_clr got %b want 0", cnt_clear); end
      rst = 1'b0;
   endtask

   task automatic test_single_run();
      reset_dut();
      len_0 = 4'd5; req = 2'b01;
      record(10, 0, 0, 8, 2'b00, 0, 2'b00);
      checks++; if (gnt_tr[1] !== 2'b01)  begin errors++; $display("FAIL single_gnt1 got %b want 01", gnt_tr[1]); end
      checks++; if (busy_tr[1] !== 1'b1)  begin errors++; $display("FAIL single_busy1 got %b want 1", busy_tr[1]); end
      checks++; if (clr_tr[1] !== 1'b1)   begin errors++; $display("FAIL single_clr1 got %b want 1", clr_tr[1]); end
      checks++; if (sum_clr(1, 10) != 1)  begin errors++; $display("FAIL single_clr_cycles got %0d want 1", sum_clr(1, 10)); end
      checks++; if (sum_en(1, 10) != 5)   begin errors++; $display("FAIL single_enables got %0d want 5", sum_en(1, 10)); end
      checks++; if (en_tr[7] !== 1'b0)    begin errors++; $display("FAIL single_en_at_len got %b want 0", en_tr[7]); end
      checks++; if (cnt_tr[8] !== 4'd5)   begin errors++; $display("FAIL single_count got %0d want 5", cnt_tr[8]); end
      checks++; if (done_tr[7] !== 2'b00) begin errors++; $display("FAIL single_done7 got %b want 00", done_tr[7]); end
      checks++; if (done_tr[8] !== 2'b01) begin errors++; $display("FAIL single_done8 got %b want 01", done_tr[8]); end
      checks++; if (gnt_tr[8] !== 2'b01)  begin errors++; $display("FAIL single_gnt8 got %b want 01", gnt_tr[8]); end
      checks++; if (done_tr[9] !== 2'b00) begin errors++; $display("FAIL single_done9 got %b want 00", done_tr[9]); end
      checks++; if (gnt_tr[9] !== 2'b00)  begin errors++; $display("FAIL single_gnt9 got %b want 00", gnt_tr[9]); end
      checks++; if (busy_tr[9] !== 1'b0)  begin errors++; $display("FAIL single_busy9 got %b want 0", busy_tr[9]); end
      checks++; if (gnt_tr[10] !== 2'b00) begin errors++; $display("FAIL single_gnt10 got %b want 00", gnt_tr[10]); end
   endtask

   task automatic test_contention();
      int         s;
      int         len;
      logic [1:0] who;
      reset_dut();
      len_0 = 4'd3; len_1 = 4'd2; req = 2'b11;
      record(30, 0, 0, 0, 2'b00, 0, 2'b00);
      s = 1;
      for (int r = 0; r < 4; r++) begin
`ifdef CNT_ARB_FIXED_PRI_EN
         who = 2'b01;
`else
         who = (r % 2 == 0) ? 2'b01 : 2'b10;
`endif
         len = (who == 2'b01) ? 3 : 2;
         checks++; if (gnt_tr[s] !== who)             begin errors++; $display("FAIL cont_gnt_start run %0d got %b want %b", r, gnt_tr[s], who); end
         checks++; if (gnt_tr[s+len+2] !== who)       begin errors++; $display("FAIL cont_gnt_end run %0d got %b want %b", r, gnt_tr[s+len+2], who); end
         checks++; if (done_tr[s+len+2] !== who)      begin errors++; $display("FAIL cont_done run %0d got %b want %b", r, done_tr[s+len+2], who); end
         checks++; if (gnt_tr[s+len+3] !== 2'b00)     begin errors++; $display("FAIL cont_release run %0d got %b want 00", r, gnt_tr[s+len+3]); end
         s = s + len + 4;
      end
      req = 2'b00;
   endtask

   task automatic test_hold();
      reset_dut();
      len_1 = 4'd4; req = 2'b10;
      record(12, 3, 3, 10, 2'b00, 0, 2'b00);
      checks++; if (gnt_tr[1] !== 2'b10)   begin errors++; $display("FAIL hold_gnt1 got %b want 10", gnt_tr[1]); end
      checks++; if (en_tr[4] !== 1'b0)     begin errors++; $display("FAIL hold_en4 got %b want 0", en_tr[4]); end
      checks++; if (cnt_tr[5] !== 4'd1)    begin errors++; $display("FAIL hold_frozen got %0d want 1", cnt_tr[5]); end
      checks++; if (done_tr[7] !== 2'b00)  begin errors++; $display("FAIL hold_done7 got %b want 00", done_tr[7]); end
      checks++; if (done_tr[10] !== 2'b10) begin errors++; $display("FAIL hold_done10 got %b want 10", done_tr[10]); end
      checks++; if (sum_en(1, 12) != 4)    begin errors++; $display("FAIL hold_enables got %0d want 4", sum_en(1, 12)); end
      checks++; if (cnt_tr[11] !== 4'd4)   begin errors++; $display("FAIL hold_count got %0d want 4", cnt_tr[11]); end
   endtask

   task automatic test_zero_len();
      reset_dut();
      len_0 = 4'd0; req = 2'b01;
      record(6, 0, 0, 3, 2'b00, 0, 2'b00);
      checks++; if (gnt_tr[1] !== 2'b01)  begin errors++; $display("FAIL zero_gnt1 got %b want 01", gnt_tr[1]); end
      checks++; if (sum_en(1, 6) != 0)    begin errors++; $display("FAIL zero_enables got %0d want 0", sum_en(1, 6)); end
      checks++; if (done_tr[2] !== 2'b00) begin errors++; $display("FAIL zero_done2 got %b want 00", done_tr[2]); end
      checks++; if (done_tr[3] !== 2'b01) begin errors++; $display("FAIL zero_done3 got %b want 01", done_tr[3]); end
      checks++; if (gnt_tr[4] !== 2'b00)  begin errors++; $display("FAIL zero_gnt4 got %b want 00", gnt_tr[4]); end
      checks++; if (cnt_tr[4] !== 4'd0)   begin errors++; $display("FAIL zero_count got %0d want 0", cnt_tr[4]); end
   endtask

   task automatic test_abort();
      logic [1:0] next_gnt;
`ifdef CNT_ARB_FIXED_PRI_EN
      next_gnt = 2'b01;
`else
      next_gnt = 2'b10;
`endif
      reset_dut();
      len_0 = 4'd15; len_1 = 4'd1; req = 2'b01;
      record(12, 0, 0, 8, 2'b10, 9, 2'b11);
      checks++; if (cnt_tr[8] !== 4'd6)   begin errors++; $display("FAIL abort_count8 got %0d want 6", cnt_tr[8]); end
      checks++; if (en_tr[7] !== 1'b1)    begin errors++; $display("FAIL abort_en7 got %b want 1", en_tr[7]); end
      checks++; if (en_tr[8] !== 1'b0)    begin errors++; $display("FAIL abort_en8 got %b want 0", en_tr[8]); end
      checks++; if (gnt_tr[9] !== 2'b00)  begin errors++; $display("FAIL abort_gnt9 got %b want 00", gnt_tr[9]); end
      checks++; if (busy_tr[9] !== 1'b0)  begin errors++; $display("FAIL abort_busy9 got %b want 0", busy_tr[9]); end
      checks++; if (cnt_tr[9] !== 4'd6)   begin errors++; $display("FAIL abort_count9 got %0d want 6", cnt_tr[9]); end
      for (int k = 1; k <= 9; k++) begin
         checks++; if (done_tr[k] !== 2'b00) begin errors++; $display("FAIL abort_no_done cycle %0d got %b want 00", k, done_tr[k]); end
      end
      checks++; if (gnt_tr[10] !== next_gnt) begin errors++; $display("FAIL abort_next_gnt got %b want %b", gnt_tr[10], next_gnt); end
      checks++; if (clr_tr[10] !== 1'b1)     begin errors++; $display("FAIL abort_next_clr got %b want 1", clr_tr[10]); end
      req = 2'b00;
   endtask

   task automatic test_rst_mid_run();
      reset_dut();
      len_0 = 4'd15; req = 2'b01;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 11) rst = 1'b1;
         if (k == 12) begin rst = 1'b0; req = 2'b00; end
         #1;
         if (k == 11) begin
            checks++; if (count !== 4'd9) begin errors++; $display("FAIL rst_count11 got %0d want 9", count); end
         end
         if (k == 12) begin
            checks++; if (gnt !== 2'b00)       begin errors++; $display("FAIL rst_gnt got %b want 00", gnt); end
            checks++; if (done !== 2'b00)      begin errors++; $display("FAIL rst_done got %b want 00", done); end
            checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
            checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", cnt_enable); end
            checks++; if (cnt_clear !== 1'b0)  begin errors++; $display("FAIL rst_clr got %b want 0", cnt_clear); end
            checks++; if (count !== 4'd0)      begin errors++; $display("FAIL rst_count got %0d want 0", count); end
         end
         if (k == 13) begin
            checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_idle_gnt got %b want 00", gnt); end
         end
      end
   endtask

   task automatic test_max_len();
      reset_dut();
      len_1 = 4'd15; req = 2'b10;
      record(20, 0, 0, 18, 2'b00, 0, 2'b00);
      checks++; if (sum_en(1, 20) != 15)   begin errors++; $display("FAIL max_enables got %0d want 15", sum_en(1, 20)); end
      checks++; if (cnt_tr[17] !== 4'd15)  begin errors++; $display("FAIL max_count got %0d want 15", cnt_tr[17]); end
      checks++; if (done_tr[17] !== 2'b00) begin errors++; $display("FAIL max_done17 got %b want 00", done_tr[17]); end
      checks++; if (done_tr[18] !== 2'b10) begin errors++; $display("FAIL max_done18 got %b want 10", done_tr[18]); end
      checks++; if (cnt_tr[19] !== 4'd15)  begin errors++; $display("FAIL max_no_wrap got %0d want 15", cnt_tr[19]); end
      checks++; if (gnt_tr[19] !== 2'b00)  begin errors++; $display("FAIL max_release got %b want 00", gnt_tr[19]); end
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; hold = 1'b0; len_0 = 4'd0; len_1 = 4'd0;
      test_reset();
      test_single_run();
      test_contention();
      test_hold();
      test_zero_len();
      test_abort();
      test_rst_mid_run();
      test_max_len();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cnt_run_arbiter.md
Name: cnt_run_arbiter

Overview:
- Shares one external binary up-counter (size-bit count, enable, synchronous clear) between two requesters.
- Each requester asks for a run of N enabled counts. The block grants round-robin, clears the counter, and drives its enable until count reaches N.
- It pulses done to the granted requester, then releases the counter.
- Sits between the requesting control units and the counter datapath; it is the counter's only source of enable and clear.

Parameters:
- size, 4, width of count and of run lengths; maximum run = 2^size-1.

Ports:
- clk  input  1  system clock; all state changes on posedge
- rst  input  1  synchronous, active-high reset
- req  input  2  per-requester run request, level; held until done or withdrawn
- len_0  input  size  run length for requester 0, sampled at grant
- len_1  input  size  run length for requester 1, sampled at grant
- hold  input  1  pause; suppresses cnt_enable while high in RUN
- count  input  size  current counter value, fed back from the datapath
- gnt  output  2  one-hot grant, registered
- done  output  2  one-cycle completion pulse to the granted requester, registered
- busy  output  1  high in any state other than IDLE
- cnt_enable  output  1  counter enable (combinational from state/hold/count)
- cnt_clear  output  1  counter synchronous clear; ORed with rst at the counter

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, gnt=00, done=00, busy=0, cnt_enable=0, cnt_clear=0, len_q=0, rr pointer favours requester 0.
- rst has priority over every other input.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requesting: grant the requester not served last (rr pointer).
  - On grant: set gnt, latch len_q from the selected len_x, go to CLEAR.
  - Latency from req seen to gnt high is 1 cycle.
- CLEAR: cnt_clear=1 for exactly one cycle, cnt_enable=0, then go to RUN.
- RUN:
  - cnt_enable = ~hold & (count != len_q).
  - When count == len_q, go to DONE; no enable is issued in that cycle.
  - len_q=0 gives zero enabled cycles: one RUN cycle, then DONE.
- DONE:
  - done[g]=1 for one cycle while gnt is still high.
  - Next cycle: gnt=00, done=00, rr pointer set to favour the other requester, state=IDLE.
  - A new grant can issue on the cycle after returning to IDLE.
- Timing, with no hold and the grant registered at edge 1:
  - gnt high cycles 1..len+3.
  - done in cycle len+3.
  - Counter sees exactly len enables.
- hold: extends RUN one cycle per held cycle; count is frozen. hold is ignored outside RUN.
- Abort: if req[g] drops in CLEAR or RUN:
  - Next edge: gnt=00, state=IDLE, no done pulse, rr pointer advances.
  - cnt_enable is forced 0 in the abort cycle.
- A request dropping in DONE does not suppress the done pulse.
- Requests from the non-granted requester are ignored until IDLE; no queueing beyond the level req.
- len_x changes after grant are ignored.
- count is never driven by this block; count > len_q (external corruption) is treated as a mismatch, so cnt_enable stays high until the counter wraps.

Optional Feature:
- CNT_ARB_FIXED_PRI_EN
  - Defined: fixed priority; requester 0 wins whenever both request; rr pointer removed.
  - Undefined (default): round-robin as described.

Decomposition:
- Package cnt_arb_pkg:
  - FSM state typedef (IDLE, CLEAR, RUN, DONE).
  - Default size constant.
  - Requester index constants.
- One natural sub-module: rr_pick_2, a combinational two-way round-robin selector (req, pointer -> one-hot pick).
  - Replaced by a fixed-priority pick under CNT_ARB_FIXED_PRI_EN.
- FSM, len_q register and output logic stay in cnt_run_arbiter.

Test Plan:
- Single run: rst 2 cycles, req=01, len_0=5, counter model attached.
  - gnt=01 one cycle after req.
  - cnt_clear one cycle.
  - Exactly 5 enables; count=5.
  - done=01 one cycle; gnt=00 next cycle.
- Contention: req=11 from reset, len_0=3, len_1=2, both held.
  - Grant order 0, 1, 0, 1.
  - Each done pulse after len+3 cycles of gnt.
  - With CNT_ARB_FIXED_PRI_EN: always 0.
- Hold: req=10, len_1=4, hold high 3 cycles mid-run.
  - count freezes.
  - done arrives 3 cycles later than without hold.
  - Total enables = 4.
- Zero length: req=01, len_0=0.
  - Zero enables.
  - done in cycle 3 after grant.
  - count stays 0.
- Abort and reset: req=01, len_0=15.
  - Drop req at count=6: gnt=00 next cycle, no done, cnt_enable=0, next grant goes to requester 1 if pending.
  - Repeat with rst=1 at count=9: all outputs 0 on next edge, state IDLE.
- Max length: size=4, len_1=15: 15 enables, count=15, done pulse, no wrap to 0.
